// File: rtl/id_ex_if.sv
// Decode-to-execute bus: decode-side inputs, the EX-stage register outputs, and the stall/flush controls.
// The stage uses the slave modport. The environment (decode, hazard control, testbench) uses the master modport.
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_data1;
    logic [DATA_W-1:0] id_data2;
    logic [DATA_W-1:0] id_imm;
    logic [9:0]        id_ctrl;
    logic              ex_stall;
    logic              flush;

    logic              id_stall;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_data1;
    logic [DATA_W-1:0] ex_data2;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_dest;
    logic [9:0]        ex_ctrl;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_data1, id_data2, id_imm, id_ctrl,
               ex_stall, flush,
        input  id_stall, ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_dest,
               ex_ctrl, bubble_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_data1, id_data2, id_imm, id_ctrl,
               ex_stall, flush,
        output id_stall, ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rs, ex_rt, ex_dest,
               ex_ctrl, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Also detects load-use hazards, inserts bubbles and keeps a saturating count of them.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic   clk,
    input logic   rst_n,
    id_ex_if.slave bus
);
    // id_ctrl / ex_ctrl bit layout: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0]}
    localparam int CTRL_MEM_READ = 8;
    localparam int CTRL_REG_DST  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
        logic [9:0]        ctrl;
    } ex_slot_t;

    ex_slot_t         ex_d, ex_q;
    logic             ex_valid_d, ex_valid_q;
    logic [CNT_W-1:0] bubble_count_d, bubble_count_q;
    logic             hazard;
    logic             bubble;

    // The load in EX produces its data too late for an instruction in ID that reads the load's destination.
    assign hazard = bus.id_valid & ex_valid_q & ex_q.ctrl[CTRL_MEM_READ] & (ex_q.dest != '0)
                  & ((ex_q.dest == bus.id_rs) | (ex_q.dest == bus.id_rt));

    assign bus.id_stall = !bus.flush & (hazard | bus.ex_stall);

    always_comb begin
        // NOTE: every *_d gets a default first, so no path through this block can infer a latch.
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        bubble     = 1'b0;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
            ex_d.ctrl  = '0;
            bubble     = 1'b1;
        end else if (bus.ex_stall) begin
            ex_d       = ex_q;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
            ex_d.ctrl  = '0;
            bubble     = 1'b1;
        end else begin
            ex_valid_d = bus.id_valid;
            ex_d.pc    = bus.id_pc;
            ex_d.data1 = bus.id_data1;
            ex_d.data2 = bus.id_data2;
            ex_d.imm   = bus.id_imm;
            ex_d.rs    = bus.id_rs;
            ex_d.rt    = bus.id_rt;
            ex_d.dest  = bus.id_ctrl[CTRL_REG_DST] ? bus.id_rd : bus.id_rt;
            // An empty decode slot must never carry control into EX.
            ex_d.ctrl  = bus.id_valid ? bus.id_ctrl : '0;
        end

        bubble_count_d = bubble_count_q;
        if (bubble && (bubble_count_q != CNT_MAX)) begin
            bubble_count_d = bubble_count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // The data fields are reset along with the control fields, so every EX output reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q           <= '0;
            ex_valid_q     <= 1'b0;
            bubble_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            ex_valid_q     <= ex_valid_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_data1     = ex_q.data1;
    assign bus.ex_data2     = ex_q.data2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_dest      = ex_q.dest;
    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.bubble_count = bubble_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// Expected values are hand-computed constants written inline at each step.
module tb_id_ex_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    // Control words: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0]}
    localparam logic [9:0] CTRL_RTYPE = 10'h210;  // reg_write, reg_dst
    localparam logic [9:0] CTRL_LW    = 10'h360;  // reg_write, mem_read, mem_to_reg, alu_src
    localparam logic [9:0] CTRL_ADD   = 10'h212;  // reg_write, reg_dst, alu_op=2
    localparam logic [9:0] CTRL_SUB   = 10'h213;  // reg_write, reg_dst, alu_op=3

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    id_ex_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [9:0] ctrl);
        bus.id_valid = v;
        bus.id_pc    = pc;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_rd    = rd;
        bus.id_data1 = d1;
        bus.id_data2 = d2;
        bus.id_imm   = imm;
        bus.id_ctrl  = ctrl;
    endtask

    // Outputs are sampled 1 ns after the rising edge, well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 10'h0);

        #12;
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_ex_ctrl", bus.ex_ctrl, 0);
        check("rst_ex_pc", bus.ex_pc, 0);
        check("rst_bubbles", bus.bubble_count, 0);
        check("rst_id_stall", bus.id_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic capture: reg_dst=1 selects rd as the destination.
        tick();
        drive(1'b1, 32'h4, 5'd1, 5'd3, 5'd5, 32'h11, 32'h22, 32'hFFFF_FFF0, CTRL_RTYPE);
        #1 check("cap_id_stall", bus.id_stall, 0);
        tick();
        check("cap_ex_valid", bus.ex_valid, 1);
        check("cap_ex_pc", bus.ex_pc, 32'h4);
        check("cap_ex_data1", bus.ex_data1, 32'h11);
        check("cap_ex_data2", bus.ex_data2, 32'h22);
        check("cap_ex_imm", bus.ex_imm, 32'hFFFF_FFF0);
        check("cap_ex_rs", bus.ex_rs, 1);
        check("cap_ex_rt", bus.ex_rt, 3);
        check("cap_ex_dest", bus.ex_dest, 5);
        check("cap_ex_ctrl", bus.ex_ctrl, CTRL_RTYPE);

        // Load-use on rs: lw $8 in EX, add reading $8 in ID.
        drive(1'b1, 32'h8, 5'd2, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, CTRL_LW);
        tick();
        check("lw_ex_dest", bus.ex_dest, 8);
        check("lw_ex_ctrl", bus.ex_ctrl, CTRL_LW);
        drive(1'b1, 32'hC, 5'd8, 5'd9, 5'd10, 32'h0, 32'h9, 32'h0, CTRL_ADD);
        #1 check("lu_id_stall", bus.id_stall, 1);
        tick();
        check("lu_bubble_valid", bus.ex_valid, 0);
        check("lu_bubble_ctrl", bus.ex_ctrl, 0);
        check("lu_bubble_count", bus.bubble_count, 1);
        check("lu_stall_released", bus.id_stall, 0);
        tick();
        check("lu_add_valid", bus.ex_valid, 1);
        check("lu_add_pc", bus.ex_pc, 32'hC);
        check("lu_add_dest", bus.ex_dest, 10);
        check("lu_add_ctrl", bus.ex_ctrl, CTRL_ADD);
        check("lu_count_hold", bus.bubble_count, 1);

        // Load to $0 never stalls, even though the add reads $0.
        drive(1'b1, 32'h10, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, CTRL_LW);
        tick();
        check("lw0_ex_dest", bus.ex_dest, 0);
        drive(1'b1, 32'h14, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, CTRL_ADD);
        #1 check("lw0_id_stall", bus.id_stall, 0);
        tick();
        check("lw0_add_valid", bus.ex_valid, 1);
        check("lw0_add_pc", bus.ex_pc, 32'h14);
        check("lw0_count", bus.bubble_count, 1);

        // Downstream hold for 3 cycles keeps the add (pc 0x14) in EX.
        drive(1'b1, 32'h18, 5'd1, 5'd2, 5'd12, 32'h33, 32'h44, 32'h0, CTRL_SUB);
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_id_stall", bus.id_stall, 1);
            tick();
            check("hold_ex_valid", bus.ex_valid, 1);
            check("hold_ex_pc", bus.ex_pc, 32'h14);
            check("hold_ex_dest", bus.ex_dest, 11);
            check("hold_ex_ctrl", bus.ex_ctrl, CTRL_ADD);
            check("hold_count", bus.bubble_count, 1);
        end
        bus.ex_stall = 1'b0;
        #1 check("rel_id_stall", bus.id_stall, 0);
        tick();
        check("rel_ex_pc", bus.ex_pc, 32'h18);
        check("rel_ex_dest", bus.ex_dest, 12);
        check("rel_ex_data1", bus.ex_data1, 32'h33);
        check("rel_ex_ctrl", bus.ex_ctrl, CTRL_SUB);

        // Flush beats ex_stall and a live hazard.
        drive(1'b1, 32'h1C, 5'd2, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0, CTRL_LW);
        tick();
        drive(1'b1, 32'h20, 5'd3, 5'd8, 5'd13, 32'h0, 32'h0, 32'h0, CTRL_ADD);
        bus.ex_stall = 1'b1;
        #1 check("pre_flush_id_stall", bus.id_stall, 1);
        bus.flush = 1'b1;
        #1 check("flush_id_stall", bus.id_stall, 0);
        tick();
        check("flush_ex_valid", bus.ex_valid, 0);
        check("flush_ex_ctrl", bus.ex_ctrl, 0);
        check("flush_count", bus.bubble_count, 2);
        bus.flush    = 1'b0;
        bus.ex_stall = 1'b0;

        // Asynchronous reset between edges while an instruction sits in EX.
        tick();
        check("pre_rst_ex_valid", bus.ex_valid, 1);
        check("pre_rst_ex_pc", bus.ex_pc, 32'h20);
        #2;
        bus.ex_stall = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_ex_valid", bus.ex_valid, 0);
        check("arst_ex_pc", bus.ex_pc, 0);
        check("arst_ex_dest", bus.ex_dest, 0);
        check("arst_ex_ctrl", bus.ex_ctrl, 0);
        check("arst_count", bus.bubble_count, 0);
        check("arst_stall_from_ex", bus.id_stall, 1);
        bus.ex_stall = 1'b0;
        #1 check("arst_no_hazard", bus.id_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the bubble counter.
        bus.flush = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        check("sat_fffe", bus.bubble_count, 16'hFFFE);
        tick();
        check("sat_ffff", bus.bubble_count, 16'hFFFF);
        tick();
        check("sat_hold", bus.bubble_count, 16'hFFFF);
        check("sat_ex_valid", bus.ex_valid, 0);
        bus.flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
